// File: rtl/cordic_scan_scheduler.sv
// cordic_scan_scheduler: front-end raster scheduler for the CORDIC pixel pipeline.
// Accepts shape descriptors over valid/ready. For each shape it walks the
// screen-clamped bounding box in raster order (x fastest) and drives one pixel
// per cycle on the nst1_* stage-1 inputs. It inserts bubbles when idle, between
// shapes and for empty boxes, and freezes on pipe_stall.
// Optional build macro: SCAN_PREFETCH_EN adds a one-entry descriptor buffer so
// the next shape can be accepted while the current one is still being scanned.
module cordic_scan_scheduler #(
    parameter int PIX_W    = 10,
    parameter int REF_W    = 9,
    parameter int COLOR_W  = 9,
    parameter int SIZE_W   = 7,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shape_valid,
    output logic               shape_ready,
    input  logic [REF_W-1:0]   shape_ref_x,
    input  logic [REF_W-1:0]   shape_ref_y,
    input  logic [SIZE_W-1:0]  shape_size,
    input  logic               shape_form,
    input  logic [COLOR_W-1:0] shape_color,
    input  logic               pipe_stall,
    output logic               nst1_bubble,
    output logic [PIX_W-1:0]   nst1_pixel_x,
    output logic [PIX_W-1:0]   nst1_pixel_y,
    output logic [REF_W-1:0]   nst1_ref_point_x,
    output logic [REF_W-1:0]   nst1_ref_point_y,
    output logic               nst1_form,
    output logic [COLOR_W-1:0] nst1_color,
    output logic [SIZE_W-1:0]  size,
    output logic               shape_done,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

    // Bounds arithmetic is two bits wider than a pixel so ref-size can go
    // negative and ref+size can exceed the screen without wrapping.
    localparam int BW = PIX_W + 2;
    localparam logic signed [BW-1:0] MAX_X = BW'(SCREEN_W - 1);
    localparam logic signed [BW-1:0] MAX_Y = BW'(SCREEN_H - 1);

    state_t state, state_next;

    logic [PIX_W-1:0] x_lo, x_hi, y_hi;
    logic [PIX_W-1:0] cur_x, cur_y;

    logic signed [BW-1:0] rx_s, ry_s, sz_s;
    logic signed [BW-1:0] dx_lo, dx_hi, dy_lo, dy_hi;
    logic signed [BW-1:0] lo_x_s, hi_x_s, lo_y_s, hi_y_s;
    logic                 box_empty;

    logic handshake;   // descriptor accepted on this edge
    logic take_now;    // accepted descriptor starts a shape immediately
    logic pending;     // a buffered descriptor is waiting
    logic next_empty;  // descriptor storage will be free after this edge
    logic done_go;     // DONE is leaving on this edge
    logic last_x, last_pix;

    logic             bubble_d, done_d, ready_d, busy_d;
    logic [PIX_W-1:0] px_d, py_d;

    assign handshake = shape_valid && shape_ready;
    assign done_go   = (state == S_DONE) && !pipe_stall;
    assign take_now  = handshake && ((state == S_IDLE) || done_go);
    assign last_x    = (cur_x == x_hi);
    assign last_pix  = last_x && (cur_y == y_hi);

    // Clamped bounding box of the latched descriptor, evaluated during LOAD.
    assign rx_s   = BW'(nst1_ref_point_x);
    assign ry_s   = BW'(nst1_ref_point_y);
    assign sz_s   = BW'(size);
    assign dx_lo  = rx_s - sz_s;
    assign dx_hi  = rx_s + sz_s;
    assign dy_lo  = ry_s - sz_s;
    assign dy_hi  = ry_s + sz_s;
    assign lo_x_s = dx_lo[BW-1] ? '0 : dx_lo;
    assign lo_y_s = dy_lo[BW-1] ? '0 : dy_lo;
    assign hi_x_s = (dx_hi > MAX_X) ? MAX_X : dx_hi;
    assign hi_y_s = (dy_hi > MAX_Y) ? MAX_Y : dy_hi;
    assign box_empty = (lo_x_s > hi_x_s) || (lo_y_s > hi_y_s);

`ifdef SCAN_PREFETCH_EN
    logic               buf_valid;
    logic [REF_W-1:0]   buf_ref_x, buf_ref_y;
    logic [SIZE_W-1:0]  buf_size;
    logic               buf_form;
    logic [COLOR_W-1:0] buf_color;

    assign pending    = buf_valid;
    assign next_empty = !((handshake && !take_now) || (buf_valid && !done_go));

    // One-entry prefetch slot: filled by a handshake that cannot start at once,
    // drained when DONE hands the buffered shape to LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_ref_x <= '0;
            buf_ref_y <= '0;
            buf_size  <= '0;
            buf_form  <= 1'b0;
            buf_color <= '0;
        end else if (handshake && !take_now) begin
            buf_valid <= 1'b1;
            buf_ref_x <= shape_ref_x;
            buf_ref_y <= shape_ref_y;
            buf_size  <= shape_size;
            buf_form  <= shape_form;
            buf_color <= shape_color;
        end else if (done_go) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign pending    = 1'b0;
    assign next_empty = (state_next == S_IDLE);
`endif

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; a stall freezes everything except IDLE acceptance.
    // NOTE: every combinational output gets a default first so no path can
    // infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (handshake) state_next = S_LOAD;
            S_LOAD: if (!pipe_stall) state_next = box_empty ? S_DONE : S_SCAN;
            S_SCAN: if (!pipe_stall && last_pix) state_next = S_DONE;
            S_DONE: if (!pipe_stall) state_next = (pending || take_now) ? S_LOAD : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; held while stalled.
    always_comb begin
        bubble_d = nst1_bubble;
        done_d   = shape_done;
        px_d     = nst1_pixel_x;
        py_d     = nst1_pixel_y;
        if (!pipe_stall) begin
            bubble_d = (state != S_SCAN);
            done_d   = (state == S_DONE);
            if (state == S_SCAN) begin
                px_d = cur_x;
                py_d = cur_y;
            end
        end
        busy_d  = (state_next != S_IDLE);
        ready_d = next_empty;
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nst1_bubble  <= 1'b1;
            shape_done   <= 1'b0;
            shape_ready  <= 1'b1;
            busy         <= 1'b0;
            nst1_pixel_x <= '0;
            nst1_pixel_y <= '0;
        end else begin
            nst1_bubble  <= bubble_d;
            shape_done   <= done_d;
            shape_ready  <= ready_d;
            busy         <= busy_d;
            nst1_pixel_x <= px_d;
            nst1_pixel_y <= py_d;
        end
    end

    // Active descriptor: taken straight from the inputs or from the prefetch slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nst1_ref_point_x <= '0;
            nst1_ref_point_y <= '0;
            size             <= '0;
            nst1_form        <= 1'b0;
            nst1_color       <= '0;
        end else if (take_now) begin
            nst1_ref_point_x <= shape_ref_x;
            nst1_ref_point_y <= shape_ref_y;
            size             <= shape_size;
            nst1_form        <= shape_form;
            nst1_color       <= shape_color;
        end
`ifdef SCAN_PREFETCH_EN
        else if (done_go && buf_valid) begin
            nst1_ref_point_x <= buf_ref_x;
            nst1_ref_point_y <= buf_ref_y;
            size             <= buf_size;
            nst1_form        <= buf_form;
            nst1_color       <= buf_color;
        end
`endif
    end

    // Bounds capture in LOAD and raster walk in SCAN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_lo  <= '0;
            x_hi  <= '0;
            y_hi  <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else if (!pipe_stall) begin
            if (state == S_LOAD) begin
                x_lo  <= lo_x_s[PIX_W-1:0];
                x_hi  <= hi_x_s[PIX_W-1:0];
                y_hi  <= hi_y_s[PIX_W-1:0];
                cur_x <= lo_x_s[PIX_W-1:0];
                cur_y <= lo_y_s[PIX_W-1:0];
            end else if (state == S_SCAN) begin
                if (last_x) begin
                    cur_x <= x_lo;
                    cur_y <= cur_y + PIX_W'(1);
                end else begin
                    cur_x <= cur_x + PIX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_scan_scheduler.sv
// Directed bench for cordic_scan_scheduler. A negedge monitor logs every
// non-bubble pixel and every shape_done pulse with a cycle stamp; the
// stimulus compares the logs against hand-computed expectations.
module tb_cordic_scan_scheduler;
    localparam int PIX_W   = 10;
    localparam int REF_W   = 9;
    localparam int COLOR_W = 9;
    localparam int SIZE_W  = 7;

    logic               clk = 1'b0;
    logic               reset;
    logic               shape_valid;
    logic               shape_ready;
    logic [REF_W-1:0]   shape_ref_x, shape_ref_y;
    logic [SIZE_W-1:0]  shape_size;
    logic               shape_form;
    logic [COLOR_W-1:0] shape_color;
    logic               pipe_stall;
    logic               nst1_bubble;
    logic [PIX_W-1:0]   nst1_pixel_x, nst1_pixel_y;
    logic [REF_W-1:0]   nst1_ref_point_x, nst1_ref_point_y;
    logic               nst1_form;
    logic [COLOR_W-1:0] nst1_color;
    logic [SIZE_W-1:0]  size;
    logic               shape_done;
    logic               busy;

    cordic_scan_scheduler dut (
        .clk(clk), .reset(reset),
        .shape_valid(shape_valid), .shape_ready(shape_ready),
        .shape_ref_x(shape_ref_x), .shape_ref_y(shape_ref_y),
        .shape_size(shape_size), .shape_form(shape_form), .shape_color(shape_color),
        .pipe_stall(pipe_stall),
        .nst1_bubble(nst1_bubble), .nst1_pixel_x(nst1_pixel_x), .nst1_pixel_y(nst1_pixel_y),
        .nst1_ref_point_x(nst1_ref_point_x), .nst1_ref_point_y(nst1_ref_point_y),
        .nst1_form(nst1_form), .nst1_color(nst1_color), .size(size),
        .shape_done(shape_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    int x_q[$], y_q[$], c_q[$], d_q[$], col_q[$], done_q[$];

    // Log pixel and done events away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (!nst1_bubble) begin
                x_q.push_back(int'(nst1_pixel_x));
                y_q.push_back(int'(nst1_pixel_y));
                c_q.push_back(cyc);
                d_q.push_back(int'({nst1_ref_point_x, nst1_ref_point_y, size, nst1_form}));
                col_q.push_back(int'(nst1_color));
            end
            if (shape_done) done_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pix(input int x, input int y);
        return (x << 16) | y;
    endfunction

    function automatic int desc(input int rx, input int ry, input int sz, input int form);
        return (rx << 17) | (ry << 8) | (sz << 1) | form;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        x_q.delete(); y_q.delete(); c_q.delete();
        d_q.delete(); col_q.delete(); done_q.delete();
    endtask

    // Offer one descriptor and return the cycle stamp of its handshake edge.
    task automatic send_shape(input int rx, input int ry, input int sz,
                              input int form, input int color, output int hs);
        int n;
        n = 0;
        step();
        shape_valid = 1'b1;
        shape_ref_x = REF_W'(rx);
        shape_ref_y = REF_W'(ry);
        shape_size  = SIZE_W'(sz);
        shape_form  = form[0];
        shape_color = COLOR_W'(color);
        while (!shape_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("handshake_timeout", n, 0);
        @(posedge clk);
        step();
        hs = cyc;
        shape_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (done_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check("done_count", done_q.size(), n);
    endtask

    int hs, hs2, ymax, idx;
    bit found;
    int stall_exp[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        shape_valid = 1'b0;
        shape_ref_x = '0;
        shape_ref_y = '0;
        shape_size  = '0;
        shape_form  = 1'b0;
        shape_color = '0;
        pipe_stall  = 1'b0;
        repeat (3) step();

        // Reset values.
        check("rst_bubble", int'(nst1_bubble), 1);
        check("rst_ready",  int'(shape_ready), 1);
        check("rst_busy",   int'(busy), 0);
        check("rst_done",   int'(shape_done), 0);
        check("rst_pix",    pix(int'(nst1_pixel_x), int'(nst1_pixel_y)), 0);
        check("rst_desc",   int'({nst1_ref_point_x, nst1_ref_point_y, size, nst1_form}), 0);
        check("rst_color",  int'(nst1_color), 0);
        reset = 1'b0;
        repeat (2) step();

        // Size 0: exactly one pixel at the reference point.
        clear_log();
        send_shape(100, 50, 0, 0, 'h0AA, hs);
        wait_done(1, 20);
        check("A_count", x_q.size(), 1);
        if (x_q.size() > 0) begin
            check("A_pix", pix(x_q[0], y_q[0]), pix(100, 50));
            check("A_latency", c_q[0] - hs, 2);
        end
        if (done_q.size() > 0) check("A_done_latency", done_q[0] - hs, 3);
        check("A_busy", int'(busy), 0);
        check("A_ready", int'(shape_ready), 1);

        // Size 1: 3x3 raster, consecutive cycles, constant descriptor.
        clear_log();
        send_shape(10, 20, 1, 1, 'h155, hs);
        wait_done(1, 30);
        check("B_count", x_q.size(), 9);
        for (int i = 0; i < x_q.size() && i < 9; i++) begin
            check($sformatf("B_pix%0d", i), pix(x_q[i], y_q[i]), pix(9 + i % 3, 19 + i / 3));
            check($sformatf("B_cyc%0d", i), c_q[i] - hs, 2 + i);
            check($sformatf("B_desc%0d", i), d_q[i], desc(10, 20, 1, 1));
            check($sformatf("B_col%0d", i), col_q[i], 'h155);
        end

        // Clamp at the low edges: x 0..7, y 0..8.
        clear_log();
        send_shape(2, 3, 5, 0, 'h001, hs);
        wait_done(1, 120);
        check("C_count", x_q.size(), 72);
        idx = 0;
        for (int y = 0; y <= 8; y++) begin
            for (int x = 0; x <= 7; x++) begin
                if (idx < x_q.size())
                    check($sformatf("C_pix%0d", idx), pix(x_q[idx], y_q[idx]), pix(x, y));
                idx++;
            end
        end

        // Clamp at the bottom edge: x 491..531, y 450..479.
        clear_log();
        send_shape(511, 470, 20, 1, 'h1FF, hs);
        wait_done(1, 1400);
        check("D_count", x_q.size(), 41 * 30);
        ymax = 0;
        foreach (y_q[i]) if (y_q[i] > ymax) ymax = y_q[i];
        check("D_ymax", ymax, 479);
        if (x_q.size() > 0) begin
            check("D_first", pix(x_q[0], y_q[0]), pix(491, 450));
            check("D_last", pix(x_q[x_q.size()-1], y_q[y_q.size()-1]), pix(531, 479));
        end

        // Empty box (y_lo 501 > 479): no pixels, done two cycles after handshake.
        clear_log();
        send_shape(5, 511, 10, 0, 'h0F0, hs);
        wait_done(1, 20);
        check("E_count", x_q.size(), 0);
        if (done_q.size() > 0) check("E_done_latency", done_q[0] - hs, 2);

        // Stall for 3 edges while (9,20) is displayed.
        clear_log();
        send_shape(10, 20, 1, 1, 'h155, hs);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (!nst1_bubble && nst1_pixel_x == 9 && nst1_pixel_y == 20) found = 1'b1;
        end
        check("F_found", int'(found), 1);
        pipe_stall = 1'b1;
        repeat (3) step();
        pipe_stall = 1'b0;
        wait_done(1, 30);
        stall_exp = '{pix(9, 19), pix(10, 19), pix(11, 19),
                      pix(9, 20), pix(9, 20), pix(9, 20), pix(9, 20),
                      pix(10, 20), pix(11, 20), pix(9, 21), pix(10, 21), pix(11, 21)};
        check("F_count", x_q.size(), 12);
        for (int i = 0; i < x_q.size() && i < 12; i++)
            check($sformatf("F_pix%0d", i), pix(x_q[i], y_q[i]), stall_exp[i]);

        // Reset in the middle of a scan.
        clear_log();
        send_shape(10, 20, 1, 0, 'h022, hs);
        for (int k = 0; k < 30 && x_q.size() < 5; k++) step();
        check("G_partial", x_q.size(), 5);
        reset = 1'b1;
        #1;
        check("G_bubble", int'(nst1_bubble), 1);
        check("G_busy",   int'(busy), 0);
        check("G_ready",  int'(shape_ready), 1);
        check("G_done",   int'(shape_done), 0);
        repeat (2) step();
        reset = 1'b0;
        repeat (6) step();
        check("G_no_done", done_q.size(), 0);
        check("G_no_more", x_q.size(), 5);

`ifdef SCAN_PREFETCH_EN
        // Back-to-back shapes: two bubbles between the pixel runs.
        clear_log();
        send_shape(10, 20, 1, 1, 'h155, hs);
        send_shape(100, 50, 0, 0, 'h0AA, hs2);
        wait_done(2, 60);
        check("H_count", x_q.size(), 10);
        if (x_q.size() == 10) begin
            check("H_last_a", pix(x_q[8], y_q[8]), pix(11, 21));
            check("H_pix_b", pix(x_q[9], y_q[9]), pix(100, 50));
            check("H_gap", c_q[9] - c_q[8], 3);
            check("H_desc_b", d_q[9], desc(100, 50, 0, 0));
        end
`else
        // Descriptors offered while busy are ignored.
        clear_log();
        send_shape(10, 20, 1, 1, 'h155, hs);
        check("H_ready_busy", int'(shape_ready), 0);
        check("H_busy", int'(busy), 1);
        shape_valid = 1'b1;
        shape_ref_x = REF_W'(200);
        shape_ref_y = REF_W'(100);
        shape_size  = SIZE_W'(2);
        repeat (3) step();
        shape_valid = 1'b0;
        wait_done(1, 30);
        repeat (4) step();
        check("H_count", x_q.size(), 9);
        check("H_idle", int'(busy), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
